blake2s_block_ctrl: RTL and testbench
=====================================

# blake2s_block_ctrl

Sequencer between the byte-oriented host interface and the `blake2s_hash256` core. It accepts a hash job (key length, digest length, message length) and pulls key and message bytes from a valid/ready source. It frames them into 64-byte blocks with zero padding, gates every block on core readiness, and drives `block_first`/`block_last`. It reports job completion once the core raises its hash-valid.

## Interface
Parameters:
- `LL_W`, 64: width of the message byte-length field and the remaining-byte counter.
- `MAX_NN`, 32: maximum digest length in bytes; also the maximum key length.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous active-high reset.
- `start_i` in 1: job request, sampled only in IDLE.
- `kk_i` in 6: key length in bytes.
- `nn_i` in 6: digest length in bytes.
- `ll_i` in LL_W: message length in bytes.
- `abort_i` in 1: cancel the current job.
- `src_valid_i` in 1: source byte valid.
- `src_data_i` in 8: source byte.
- `src_ready_o` out 1: controller accepts a source byte.
- `ready_v_i` in 1: core can accept a new block.
- `h_v_i` in 1: core digest valid.
- `kk_o` out 6: latched job configuration to the core.
- `nn_o` out 6: latched job configuration to the core.
- `ll_o` out LL_W: latched job configuration to the core.
- `data_v_o` out 1: byte to core valid.
- `data_o` out 8: byte to core.
- `data_idx_o` out 6: byte position within the block.
- `block_first_o` out 1: current block is the first block.
- `block_last_o` out 1: current block is the last block.
- `busy_o` out 1: job in progress.
- `done_o` out 1: one-cycle pulse when the job completes.
- `err_o` out 1: one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, WAIT_RDY, STREAM, WAIT_HASH.
- IDLE, `start_i`=1:
  - Rejected if `nn_i`=0, `nn_i`>MAX_NN or `kk_i`>MAX_NN. The block pulses `err_o` and stays in IDLE.
  - Otherwise it latches the configuration into `kk_o`/`nn_o`/`ll_o`, sets the block-first flag, loads `rem`=`ll_i` and goes to WAIT_RDY.
- Block source-byte count `src_cnt`:
  - Key block (first block, `kk`>0): `kk`.
  - Message block: min(`rem`,64).
- Block-last rule: the block is last when it is a message block with `rem`≤64, or a key block with `ll`=0.
  - `ll`=0, `kk`=0: exactly one block, all zero padding, with first=last=1.
- WAIT_RDY: the block waits for `ready_v_i`=1, then enters STREAM with idx=0.
  - The first cycle after entry is blanked: `ready_v_i` is ignored on that cycle.
- STREAM, per cycle:
  - idx<`src_cnt`: `src_ready_o`=1. A source handshake emits that byte and increments idx. With no handshake, nothing is emitted.
  - idx≥`src_cnt`: `src_ready_o`=0. A zero pad byte is emitted every cycle.
  - After idx 63 is emitted, `rem` is reduced by the message bytes of the block, the block-first flag clears, and the state goes to WAIT_HASH if the block was last, otherwise to WAIT_RDY.
- WAIT_HASH: on `h_v_i`=1 the block pulses `done_o` and returns to IDLE.
- `abort_i` (any state other than IDLE):
  - Next state is IDLE.
  - `data_v_o`, `src_ready_o` and `busy_o` go low on the next cycle.
  - No `done_o` pulse.
  - The core is not notified.
- `start_i` outside IDLE is ignored.
- `abort_i` has priority over every other transition, including a same-cycle handshake.

## Timing
- Reset values: all outputs 0; state IDLE.
- `src_ready_o` is combinational from state and idx.
- `data_*` and `block_*` outputs are registered, one cycle after the handshake or pad decision.
- `block_first_o`/`block_last_o` are held constant for all 64 bytes of a block and are meaningful only with `data_v_o`.
- `busy_o`: 1 from the cycle after an accepted start until the `done_o` cycle. It is 0 in the `done_o` cycle.
- Minimum block time is 64 cycles. A block that is entirely padding streams with no stalls.
- `rem` arithmetic is LL_W-wide, with no wrap. `ll`=2^64−1 is legal.

## Configuration
- `BLAKE2S_KEYED_EN` defined: key block support as described above.
- Not defined:
  - `kk_i` is ignored and `kk_o` is tied to 0.
  - No key block is ever generated.
  - A non-zero `kk_i` is not an error.

## Structure
- Shared package `blake2s_pkg`:
  - State enum.
  - `BLOCK_BYTES`=64.
  - `MAX_NN`.
  - Width constants for `kk`, `nn` and `idx`.
- Optional sub-module `blake2s_blk_cnt`: remaining-byte counter plus the block-last and `src_cnt` computation.

## Test plan
- `kk`=0, `nn`=32, `ll`=3, bytes "abc", `ready_v_i` high → one block:
  - idx 0..2 carry 61,62,63, idx 3..63 carry 0.
  - first=last=1.
  - `done_o` after `h_v_i`.
- `kk`=0, `ll`=0 → 64 zero bytes with first=last=1, and no source handshakes.
- Keyed (macro defined), `kk`=16, `ll`=64:
  - Block 1: 16 key bytes plus 48 zeros, first=1, last=0.
  - Block 2: 64 message bytes, first=0, last=1.
- `ll`=130 with `src_valid_i` toggled randomly:
  - Three blocks; the third carries 2 bytes plus 62 zeros.
  - `ready_v_i` is held low 20 cycles between blocks, with no output until it rises.
- Start with `nn`=0, or with `kk`=33 → `err_o` pulse, state stays IDLE, `busy_o`=0.
- `abort_i` at idx 10 of block 2 → IDLE next cycle with outputs low. A subsequent start with `ll`=1 completes normally.
- Assert `reset` mid-STREAM → all outputs 0 immediately.

Source files
------------

// File: rtl/blake2s_pkg.sv
// blake2s_pkg: constants and state type shared by the BLAKE2s block sequencer.
package blake2s_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int MAX_NN      = 32;
  localparam int KK_W        = 6;
  localparam int NN_W        = 6;
  localparam int IDX_W       = 6;
  localparam int CNT_W       = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RDY  = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_HASH = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/blake2s_blk_cnt.sv
// blake2s_blk_cnt: remaining message byte counter. It also decides how many
// bytes the current block pulls from the source and whether that block is the
// last one of the job.
module blake2s_blk_cnt
  import blake2s_pkg::*;
#(
  parameter int LL_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LL_W-1:0]  ll,
  input  logic             consume,
  input  logic             key_blk,
  input  logic [KK_W-1:0]  kk,
  input  logic             ll_zero,
  output logic [CNT_W-1:0] src_cnt,
  output logic             last
);

  localparam logic [LL_W-1:0] BLK_LL = LL_W'(BLOCK_BYTES);

  logic [LL_W-1:0]  rem;
  logic             rem_le_blk;
  logic [CNT_W-1:0] msg_cnt;

  // Source byte count and last-block flag: the key block is sized by kk and is
  // last only for an empty message; message blocks take min(rem, 64) bytes
  always_comb begin
    rem_le_blk = (rem <= BLK_LL);
    msg_cnt    = rem_le_blk ? rem[CNT_W-1:0] : CNT_W'(BLOCK_BYTES);
    src_cnt    = msg_cnt;
    last       = rem_le_blk;
    if (key_blk) begin
      src_cnt = {1'b0, kk};
      last    = ll_zero;
    end
  end

  // Remaining message bytes: loaded per job, reduced once per finished
  // message block; never goes below zero because msg_cnt is at most rem
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
    end else if (load) begin
      rem <= ll;
    end else if (consume && !key_blk) begin
      rem <= rem - LL_W'(msg_cnt);
    end
  end

endmodule

// File: rtl/blake2s_block_ctrl.sv
// blake2s_block_ctrl: frames key and message bytes from a valid/ready source
// into zero-padded 64-byte blocks for the blake2s_hash256 core.
// Build option: BLAKE2S_KEYED_EN enables the leading key block; without it the
// key length input is ignored and kk_o stays 0.
module blake2s_block_ctrl #(
  parameter int LL_W   = 64,
  parameter int MAX_NN = blake2s_pkg::MAX_NN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [5:0]      kk_i,
  input  logic [5:0]      nn_i,
  input  logic [LL_W-1:0] ll_i,
  input  logic            abort_i,
  input  logic            src_valid_i,
  input  logic [7:0]      src_data_i,
  output logic            src_ready_o,
  input  logic            ready_v_i,
  input  logic            h_v_i,
  output logic [5:0]      kk_o,
  output logic [5:0]      nn_o,
  output logic [LL_W-1:0] ll_o,
  output logic            data_v_o,
  output logic [7:0]      data_o,
  output logic [5:0]      data_idx_o,
  output logic            block_first_o,
  output logic            block_last_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  import blake2s_pkg::*;

  localparam logic [CNT_W-1:0] MAX_NN_W = CNT_W'(MAX_NN);

  ctrl_state_t      state_q, state_d;
  logic [KK_W-1:0]  kk_q;
  logic [NN_W-1:0]  nn_q;
  logic [LL_W-1:0]  ll_q;
  logic             first_q;
  logic             blank_q;
  logic [IDX_W-1:0] idx_q;

  logic [CNT_W-1:0] src_cnt;
  logic             blk_last;
  logic             key_blk;
  logic             kk_ok;
  logic [KK_W-1:0]  kk_cfg;
  logic             cfg_ok;
  logic             ll_zero;
  logic             in_src;
  logic             emit;
  logic             blk_end;
  logic             accept;
  logic             reject;
  logic             finish;

`ifdef BLAKE2S_KEYED_EN
  assign key_blk = first_q && (kk_q != '0);
  assign kk_ok   = ({1'b0, kk_i} <= MAX_NN_W);
  assign kk_cfg  = kk_i;
`else
  logic unused_kk;
  assign unused_kk = ^kk_i;
  assign key_blk   = 1'b0;
  assign kk_ok     = 1'b1;
  assign kk_cfg    = '0;
`endif

  assign cfg_ok  = (nn_i != '0) && ({1'b0, nn_i} <= MAX_NN_W) && kk_ok;
  assign ll_zero = (ll_q == '0);

  // While idx is below the block's source count we pull bytes; past it we pad.
  // A pad byte goes out every cycle, a source byte only on a handshake, and an
  // abort suppresses the emit even if a handshake happens in the same cycle.
  assign in_src      = ({1'b0, idx_q} < src_cnt);
  assign src_ready_o = (state_q == ST_STREAM) && in_src;
  assign emit        = (state_q == ST_STREAM) && (!in_src || src_valid_i) && !abort_i;
  assign blk_end     = emit && (idx_q == IDX_W'(BLOCK_BYTES - 1));

  assign kk_o = kk_q;
  assign nn_o = nn_q;
  assign ll_o = ll_q;

  blake2s_blk_cnt #(
    .LL_W(LL_W)
  ) u_blk_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .ll      (ll_i),
    .consume (blk_end),
    .key_blk (key_blk),
    .kk      (kk_q),
    .ll_zero (ll_zero),
    .src_cnt (src_cnt),
    .last    (blk_last)
  );

  // Next state and one-shot events; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            accept  = 1'b1;
            state_d = ST_WAIT_RDY;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (!blank_q && ready_v_i) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (blk_end) begin
          state_d = blk_last ? ST_WAIT_HASH : ST_WAIT_RDY;
        end
      end
      ST_WAIT_HASH: begin
        if (h_v_i) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      finish  = 1'b0;
    end
  end

  // State, job configuration and block bookkeeping; the first WAIT_RDY cycle
  // after entry is blanked so a stale ready from the previous block is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      blank_q <= 1'b0;
      idx_q   <= '0;
      kk_q    <= '0;
      nn_q    <= '0;
      ll_q    <= '0;
      first_q <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      blank_q <= (state_d == ST_WAIT_RDY) && (state_q != ST_WAIT_RDY);
      if (state_q == ST_WAIT_RDY) begin
        idx_q <= '0;
      end else if (emit) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (accept) begin
        kk_q    <= kk_cfg;
        nn_q    <= nn_i;
        ll_q    <= ll_i;
        first_q <= 1'b1;
      end else if (blk_end) begin
        first_q <= 1'b0;
      end
      busy_o <= (state_d != ST_IDLE);
      done_o <= finish;
      err_o  <= reject;
    end
  end

  // Registered byte stream to the core; block flags only change with a byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_v_o      <= 1'b0;
      data_o        <= '0;
      data_idx_o    <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
    end else begin
      data_v_o <= emit;
      if (emit) begin
        data_o        <= in_src ? src_data_i : 8'h00;
        data_idx_o    <= idx_q;
        block_first_o <= first_q;
        block_last_o  <= blk_last;
      end
    end
  end

endmodule

// File: tb/tb_blake2s_block_ctrl.sv
// tb_blake2s_block_ctrl: table-driven and randomized checks of the BLAKE2s
// block sequencer against a queue-based model of the expected byte stream.
module tb_blake2s_block_ctrl;

`ifdef BLAKE2S_KEYED_EN
  localparam bit KEYED = 1'b1;
`else
  localparam bit KEYED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i, abort_i, src_valid_i, ready_v_i, h_v_i;
  logic [5:0]  kk_i, nn_i;
  logic [63:0] ll_i;
  logic [7:0]  src_data_i;
  logic        src_ready_o, data_v_o, block_first_o, block_last_o;
  logic        busy_o, done_o, err_o;
  logic [5:0]  kk_o, nn_o, data_idx_o;
  logic [63:0] ll_o;
  logic [7:0]  data_o;

  always #5 clk = ~clk;

  blake2s_block_ctrl #(.LL_W(64), .MAX_NN(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
    .ll_i(ll_i), .abort_i(abort_i), .src_valid_i(src_valid_i),
    .src_data_i(src_data_i), .src_ready_o(src_ready_o), .ready_v_i(ready_v_i),
    .h_v_i(h_v_i), .kk_o(kk_o), .nn_o(nn_o), .ll_o(ll_o), .data_v_o(data_v_o),
    .data_o(data_o), .data_idx_o(data_idx_o), .block_first_o(block_first_o),
    .block_last_o(block_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [5:0] idx;
    logic       first;
    logic       last;
  } exp_byte_t;

  typedef struct {
    int kk;
    int nn;
    int ll;
    bit err;
    int blocks;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  exp_byte_t  exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] job_bytes[$];
  logic [7:0] fixed_q[$];
  bit         hs_pending = 1'b0;
  int         hs_count = 0;
  bit         rand_valid = 1'b0;
  bit         gap_mode = 1'b0;
  int         blk_seen = 0;
  exp_byte_t  mon_e;
  vec_t       vecs[10];
  int         blocks, n, hs_before, rkk, rnn, rll;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  task automatic applyStimulus(input int kk, input int nn, input logic [63:0] ll);
    @(negedge clk);
    start_i = 1'b1;
    kk_i    = 6'(kk);
    nn_i    = 6'(nn);
    ll_i    = ll;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // One expected 64-byte block: cnt source bytes from pos, then zero padding
  task automatic add_block(input int pos, input int cnt, input bit first, input bit last);
    exp_byte_t e;
    for (int i = 0; i < 64; i++) begin
      e.data  = (i < cnt) ? job_bytes[pos + i] : 8'h00;
      e.idx   = 6'(i);
      e.first = first;
      e.last  = last;
      exp_q.push_back(e);
    end
  endtask

  // Model: optional key block, then ceil(ll/64) message blocks (at least one
  // block overall), last flag on the final block of the job
  task automatic build_job(input int kk, input int ll, input bit use_fixed);
    int keyb, nmsg, cnt, pos;
    logic [7:0] b;
    keyb = KEYED ? kk : 0;
    src_q.delete();
    exp_q.delete();
    job_bytes.delete();
    blk_seen = 0;
    for (int i = 0; i < keyb + ll; i++) begin
      b = use_fixed ? fixed_q[i] : 8'($urandom_range(0, 255));
      job_bytes.push_back(b);
      src_q.push_back(b);
    end
    pos = 0;
    if (keyb > 0) begin
      add_block(0, keyb, 1'b1, ll == 0);
      pos = keyb;
    end
    nmsg = (ll + 63) / 64;
    if (nmsg == 0 && keyb == 0) nmsg = 1;
    for (int k = 0; k < nmsg; k++) begin
      cnt = ll - 64 * k;
      if (cnt > 64) cnt = 64;
      add_block(pos, cnt, (keyb == 0) && (k == 0), k == nmsg - 1);
      pos += cnt;
    end
  endtask

  task automatic clear_job();
    src_q.delete();
    exp_q.delete();
    hs_pending = 1'b0;
  endtask

  task automatic finish_job();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 6000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() > 0) timeoutFail("stream_complete");
    checkOutput("busy_before_hash", busy_o, 1);
    h_v_i = 1'b1;
    w = 0;
    while (!done_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!done_o) timeoutFail("done_pulse");
    checkOutput("busy_in_done_cycle", busy_o, 0);
    h_v_i = 1'b0;
    @(negedge clk);
    checkOutput("done_single_pulse", done_o, 0);
  endtask

  task automatic run_job(input int kk, input int nn, input int ll, input bit use_fixed, output int blks);
    build_job(kk, ll, use_fixed);
    applyStimulus(kk, nn, 64'(ll));
    checkOutput("start_err_low", err_o, 0);
    checkOutput("busy_after_start", busy_o, 1);
    checkOutput("nn_latched", nn_o, 64'(nn));
    checkOutput("ll_latched", ll_o, 64'(ll));
    checkOutput("kk_latched", kk_o, KEYED ? 64'(kk) : 64'd0);
    finish_job();
    blks = blk_seen;
  endtask

  // Source model: presents queued bytes, pops one per handshake
  always @(negedge clk) begin
    if (hs_pending) begin
      hs_count++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 2) != 0)) begin
      src_valid_i = 1'b1;
      src_data_i  = src_q[0];
    end else begin
      src_valid_i = 1'b0;
      src_data_i  = 8'h00;
    end
    hs_pending = src_valid_i && src_ready_o && !reset;
  end

  // Stream monitor: every emitted byte must match the next expected byte
  always @(negedge clk) begin
    if (!reset && data_v_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_byte actual=idx %0d required=no byte", data_idx_o);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("stream_byte", 64'({data_o, data_idx_o, block_first_o, block_last_o}), 64'(mon_e));
      end
      if (data_idx_o == 6'd63) blk_seen++;
    end
  end

  // Ready gap: hold ready low 20 cycles after each non-final block
  always @(negedge clk) begin
    if (gap_mode && !reset && data_v_o && data_idx_o == 6'd63 && !block_last_o) begin
      ready_v_i = 1'b0;
      repeat (20) begin
        @(negedge clk);
        checkOutput("gap_no_output", data_v_o, 0);
      end
      ready_v_i = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start_i = 0; abort_i = 0; ready_v_i = 1; h_v_i = 0;
    kk_i = 0; nn_i = 0; ll_i = 0;
    src_valid_i = 0; src_data_i = 0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 64'({src_ready_o, kk_o, nn_o, data_v_o, data_o, data_idx_o,
                block_first_o, block_last_o, busy_o, done_o, err_o}), 0);
    checkOutput("reset_ll_o", ll_o, 0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{0, 0, 5, 1'b1, 0};
    vecs[1] = '{0, 33, 5, 1'b1, 0};
    vecs[2] = '{0, 32, 3, 1'b0, 1};
    vecs[3] = '{0, 1, 0, 1'b0, 1};
    vecs[4] = '{0, 16, 64, 1'b0, 1};
    vecs[5] = '{0, 32, 65, 1'b0, 2};
    vecs[6] = '{33, 32, 10, KEYED, KEYED ? 0 : 1};
    vecs[7] = '{0, 20, 128, 1'b0, 2};
    vecs[8] = '{16, 32, 64, 1'b0, KEYED ? 2 : 1};
    vecs[9] = '{32, 32, 0, 1'b0, 1};

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].err) begin
        applyStimulus(vecs[v].kk, vecs[v].nn, 64'(vecs[v].ll));
        checkOutput($sformatf("vec%0d_err_pulse", v), err_o, 1);
        checkOutput($sformatf("vec%0d_err_busy", v), busy_o, 0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d_err_after", v), 64'({err_o, busy_o, data_v_o, src_ready_o}), 0);
      end else begin
        run_job(vecs[v].kk, vecs[v].nn, vecs[v].ll, 1'b0, blocks);
        checkOutput($sformatf("vec%0d_blocks", v), 64'(blocks), 64'(vecs[v].blocks));
      end
    end

    fixed_q = '{8'h61, 8'h62, 8'h63};
    run_job(0, 32, 3, 1'b1, blocks);
    checkOutput("abc_blocks", 64'(blocks), 1);

    hs_before = hs_count;
    run_job(0, 32, 0, 1'b0, blocks);
    checkOutput("ll0_no_handshake", 64'(hs_count), 64'(hs_before));
    checkOutput("ll0_blocks", 64'(blocks), 1);

    rand_valid = 1'b1;
    gap_mode   = 1'b1;
    run_job(0, 32, 130, 1'b0, blocks);
    checkOutput("ll130_blocks", 64'(blocks), 3);
    gap_mode   = 1'b0;

    rand_valid = 1'b0;
    build_job(0, 130, 1'b0);
    applyStimulus(0, 32, 64'd130);
    n = 0;
    while (!(data_v_o && data_idx_o == 6'd10 && !block_first_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeoutFail("abort_reach_block2");
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abort_outputs_low", 64'({data_v_o, src_ready_o, busy_o, done_o}), 0);
    clear_job();
    @(negedge clk);
    checkOutput("abort_stays_idle", 64'({data_v_o, busy_o, done_o}), 0);
    run_job(0, 32, 1, 1'b0, blocks);
    checkOutput("after_abort_blocks", 64'(blocks), 1);

    ready_v_i = 1'b0;
    clear_job();
    applyStimulus(0, 32, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("llmax_latched", ll_o, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("llmax_busy", busy_o, 1);
    repeat (5) @(negedge clk);
    checkOutput("llmax_wait_ready", 64'({data_v_o, src_ready_o}), 0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("llmax_abort_busy", busy_o, 0);
    ready_v_i = 1'b1;

    build_job(0, 100, 1'b0);
    applyStimulus(0, 32, 64'd100);
    n = 0;
    while (!data_v_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeoutFail("reset_reach_stream");
    reset = 1'b1;
    #1;
    checkOutput("midreset_outputs", 64'({src_ready_o, kk_o, nn_o, data_v_o, data_o, data_idx_o,
                block_first_o, block_last_o, busy_o, done_o, err_o}), 0);
    checkOutput("midreset_ll_o", ll_o, 0);
    clear_job();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    rand_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      rkk = $urandom_range(0, 32);
      rnn = $urandom_range(1, 32);
      rll = $urandom_range(0, 200);
      run_job(rkk, rnn, rll, 1'b0, blocks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
